// File: rtl/vga_framebuffer_scanout.sv
// VGA 640x480@60 scanout: timing counters, framebuffer read pipeline and sync/blank alignment.
// Sync, blanking and colour reach the pins RD_LATENCY+2 cycles after the counter value.
module vga_framebuffer_scanout #(
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned H_VIS_START = 144,
  parameter int unsigned H_VIS_END   = 783,
  parameter int unsigned V_VIS_START = 35,
  parameter int unsigned V_VIS_END   = 514,
  parameter int unsigned RD_LATENCY  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] horizontal_actual_position,
  output logic [15:0] vertical_actual_position,
  output logic        frame_start,
  output logic [18:0] rd_addr,
  output logic        rd_en,
  input  logic [11:0] rd_data,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        hsync,
  output logic        vsync
);

  localparam int unsigned D  = RD_LATENCY + 2;
  localparam int unsigned HW = $clog2(H_TOTAL);
  localparam int unsigned VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] HLast     = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] VLast     = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] HSyncEnd  = HW'(H_SYNC);
  localparam logic [VW-1:0] VSyncEnd  = VW'(V_SYNC);
  localparam logic [HW-1:0] HVisStart = HW'(H_VIS_START);
  localparam logic [HW-1:0] HVisEnd   = HW'(H_VIS_END);
  localparam logic [VW-1:0] VVisStart = VW'(V_VIS_START);
  localparam logic [VW-1:0] VVisEnd   = VW'(V_VIS_END);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  // Linear pixel index tracking v*H_TOTAL+h, avoids a multiplier
  logic [18:0]   lin_q, lin_d;
  logic [18:0]   rd_addr_q, rd_addr_d;
  logic          rd_en_q, rd_en_d;
  logic          frame_start_q, frame_start_d;
  logic [D-1:0]  hs_pipe_q, hs_pipe_d;
  logic [D-1:0]  vs_pipe_q, vs_pipe_d;
  logic [D-1:0]  vis_pipe_q, vis_pipe_d;
  logic [11:0]   rgb_q, rgb_d;

  logic h_wrap, frame_wrap, visible, hs_raw, vs_raw;

  always_comb begin
    h_wrap     = (h_q == HLast);
    frame_wrap = h_wrap && (v_q == VLast);

    h_d = h_wrap ? '0 : h_q + HW'(1);
    v_d = v_q;
    if (h_wrap) begin
      v_d = (v_q == VLast) ? '0 : v_q + VW'(1);
    end
    lin_d = frame_wrap ? '0 : lin_q + 19'd1;

    visible = (h_q >= HVisStart) && (h_q <= HVisEnd) &&
              (v_q >= VVisStart) && (v_q <= VVisEnd);
    hs_raw  = (h_q >= HSyncEnd);
    vs_raw  = (v_q >= VSyncEnd);

    rd_addr_d     = lin_q;
    rd_en_d       = visible;
    frame_start_d = frame_wrap;

    hs_pipe_d  = {hs_pipe_q[D-2:0], hs_raw};
    vs_pipe_d  = {vs_pipe_q[D-2:0], vs_raw};
    vis_pipe_d = {vis_pipe_q[D-2:0], visible};

    // Stage D-2 lines up with rd_data; blanking masks whatever the memory returns
    rgb_d = vis_pipe_q[D-2] ? rd_data : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q           <= '0;
      v_q           <= '0;
      lin_q         <= '0;
      rd_addr_q     <= '0;
      rd_en_q       <= 1'b0;
      frame_start_q <= 1'b0;
      hs_pipe_q     <= '1;
      vs_pipe_q     <= '1;
      vis_pipe_q    <= '0;
      rgb_q         <= '0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      lin_q         <= lin_d;
      rd_addr_q     <= rd_addr_d;
      rd_en_q       <= rd_en_d;
      frame_start_q <= frame_start_d;
      hs_pipe_q     <= hs_pipe_d;
      vs_pipe_q     <= vs_pipe_d;
      vis_pipe_q    <= vis_pipe_d;
      rgb_q         <= rgb_d;
    end
  end

  assign horizontal_actual_position = 16'(h_q);
  assign vertical_actual_position   = 16'(v_q);
  assign frame_start                = frame_start_q;
  assign rd_addr                    = rd_addr_q;
  assign rd_en                      = rd_en_q;
  assign vga_r                      = rgb_q[11:8];
  assign vga_g                      = rgb_q[7:4];
  assign vga_b                      = rgb_q[3:0];
  assign hsync                      = hs_pipe_q[D-1];
  assign vsync                      = vs_pipe_q[D-1];

endmodule

// File: tb/tb_vga_framebuffer_scanout.sv
// Bench for vga_framebuffer_scanout: full-size instance plus a shrunken-timing instance, both
// compared every cycle against a position/time model of the VGA raster.
module tb_vga_framebuffer_scanout;

  typedef struct {
    int ht; int vt; int hs; int vs; int hvs; int hve; int vvs; int vve; int d;
  } tp_t;

  logic clk;
  logic rst_n_a, rst_n_b;

  logic [15:0] ha, va, hb, vb;
  logic        fs_a, fs_b, en_a, en_b, hs_a, hs_b, vs_a, vs_b;
  logic [18:0] addr_a, addr_b;
  logic [11:0] data_a, data_b;
  logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;

  logic [11:0] seed_a, seed_b;
  logic [11:0] ma0, ma1, mb0, mb1, mb2;

  int checks, errors;
  int n_a, n_b;
  bit run_a, run_b;
  tp_t pa, pb;

  vga_framebuffer_scanout u_dut_a (
    .clk                        (clk),
    .rst_n                      (rst_n_a),
    .horizontal_actual_position (ha),
    .vertical_actual_position   (va),
    .frame_start                (fs_a),
    .rd_addr                    (addr_a),
    .rd_en                      (en_a),
    .rd_data                    (data_a),
    .vga_r                      (r_a),
    .vga_g                      (g_a),
    .vga_b                      (b_a),
    .hsync                      (hs_a),
    .vsync                      (vs_a)
  );

  vga_framebuffer_scanout #(
    .H_TOTAL     (50),
    .V_TOTAL     (12),
    .H_SYNC      (6),
    .V_SYNC      (2),
    .H_VIS_START (9),
    .H_VIS_END   (45),
    .V_VIS_START (3),
    .V_VIS_END   (10),
    .RD_LATENCY  (3)
  ) u_dut_b (
    .clk                        (clk),
    .rst_n                      (rst_n_b),
    .horizontal_actual_position (hb),
    .vertical_actual_position   (vb),
    .frame_start                (fs_b),
    .rd_addr                    (addr_b),
    .rd_en                      (en_b),
    .rd_data                    (data_b),
    .vga_r                      (r_b),
    .vga_g                      (g_b),
    .vga_b                      (b_b),
    .hsync                      (hs_b),
    .vsync                      (vs_b)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  // Framebuffer models: word = addr[11:0] ^ seed, unknown when not strobed
  always @(posedge clk) begin
    ma0 <= en_a ? (addr_a[11:0] ^ seed_a) : 12'hxxx;
    ma1 <= ma0;
    mb0 <= en_b ? (addr_b[11:0] ^ seed_b) : 12'hxxx;
    mb1 <= mb0;
    mb2 <= mb1;
  end
  assign data_a = ma1;
  assign data_b = mb2;

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want)
    else begin
      errors++;
      $error("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  function automatic int hpos(tp_t p, int n);
    return n % p.ht;
  endfunction

  function automatic int vpos(tp_t p, int n);
    return (n / p.ht) % p.vt;
  endfunction

  function automatic bit vis(tp_t p, int h, int v);
    return h >= p.hvs && h <= p.hve && v >= p.vvs && v <= p.vve;
  endfunction

  // n = clock edges since reset release (0 while held in reset)
  task automatic check(input string tag, input tp_t p, input int n, input logic [11:0] seed,
                       input logic [15:0] oh, input logic [15:0] ov, input logic ofs,
                       input logic [18:0] oaddr, input logic oen, input logic [11:0] orgb,
                       input logic ohs, input logic ovs);
    int h1, v1, hd, vd, eaddr;
    bit een, ehs, evs;
    logic [11:0] ergb;
    eaddr = 0; een = 0; ehs = 1; evs = 1; ergb = '0;
    if (n > 0) begin
      h1 = hpos(p, n - 1); v1 = vpos(p, n - 1);
      eaddr = v1 * p.ht + h1;
      een = vis(p, h1, v1);
    end
    if (n >= p.d) begin
      hd = hpos(p, n - p.d); vd = vpos(p, n - p.d);
      ehs = hd >= p.hs;
      evs = vd >= p.vs;
      if (vis(p, hd, vd)) ergb = 12'((vd * p.ht + hd) & 32'hfff) ^ seed;
    end
    cmp({tag, ".h"}, 32'(oh), 32'(hpos(p, n)));
    cmp({tag, ".v"}, 32'(ov), 32'(vpos(p, n)));
    cmp({tag, ".frame_start"}, 32'(ofs), 32'(n > 0 && n % (p.ht * p.vt) == 0));
    cmp({tag, ".rd_addr"}, 32'(oaddr), 32'(eaddr));
    cmp({tag, ".rd_en"}, 32'(oen), 32'(een));
    cmp({tag, ".rgb"}, 32'(orgb), 32'(ergb));
    cmp({tag, ".hsync"}, 32'(ohs), 32'(ehs));
    cmp({tag, ".vsync"}, 32'(ovs), 32'(evs));
  endtask

  task automatic check_a();
    check("A", pa, n_a, seed_a, ha, va, fs_a, addr_a, en_a, {r_a, g_a, b_a}, hs_a, vs_a);
  endtask

  task automatic check_b();
    check("B", pb, n_b, seed_b, hb, vb, fs_b, addr_b, en_b, {r_b, g_b, b_b}, hs_b, vs_b);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (run_a) n_a++;
    if (run_b) n_b++;
    check_a();
    check_b();
  endtask

  initial begin
    int b_phase, b_cnt, pre;
    checks = 0; errors = 0;
    pa = '{800, 525, 96, 2, 144, 783, 35, 514, 4};
    pb = '{50, 12, 6, 2, 9, 45, 3, 10, 5};
    seed_a = 12'($urandom);
    seed_b = 12'($urandom);
    n_a = 0; n_b = 0; run_a = 0; run_b = 0;
    rst_n_a = 1'b0; rst_n_b = 1'b0;
    repeat (3) step();
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    run_a = 1; run_b = 1;

    // Random mid-line point for the first reset of A
    pre = 200 + int'($urandom_range(0, 500));
    repeat (pre) step();
    rst_n_a = 1'b0;
    #1;
    run_a = 0; n_a = 0;
    check_a();
    repeat (10) step();
    rst_n_a = 1'b1;
    seed_a = '0;
    run_a = 1;

    b_phase = 0; b_cnt = 0;
    while (n_a < 28800) begin
      step();
      // Directed points on the full-size raster (seed 0 => rgb = addr[11:0])
      if (run_a && n_a == 28144) cmp("A.en_at_143_35", 32'(en_a), 32'd0);
      if (run_a && n_a == 28145) begin
        cmp("A.addr_at_144_35", 32'(addr_a), 32'd28144);
        cmp("A.en_at_144_35", 32'(en_a), 32'd1);
      end
      if (run_a && n_a == 28147) cmp("A.rgb_before_144_35", 32'({r_a, g_a, b_a}), 32'h000);
      if (run_a && n_a == 28148) cmp("A.rgb_at_144_35", 32'({r_a, g_a, b_a}), 32'hDF0);
      if (run_a && n_a == 28785) cmp("A.en_at_784_35", 32'(en_a), 32'd0);
      if (run_a && n_a == 28788) cmp("A.rgb_at_784_35", 32'({r_a, g_a, b_a}), 32'h000);
      // Mid-frame reset of B at (25,7) in its third frame, held 3 cycles
      if (b_phase == 0 && n_b == 2 * 600 + 7 * 50 + 25) begin
        rst_n_b = 1'b0;
        #1;
        run_b = 0; n_b = 0;
        check_b();
        b_phase = 1;
      end else if (b_phase == 1) begin
        b_cnt++;
        if (b_cnt == 3) begin
          rst_n_b = 1'b1;
          seed_b = 12'($urandom);
          run_b = 1;
          b_phase = 2;
        end
      end
    end
    cmp("B.reset_sequence_done", 32'(b_phase), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_framebuffer_scanout.md
Name: vga_framebuffer_scanout

Overview:
- Read-side counterpart of the rectangle draw blocks.
- Generates the 640x480@60 VGA timing grid (800x525 total) and exports the raw positions the draw blocks consume.
- Reads 12-bit pixels from the framebuffer at addr = v*800 + h and drives the VGA pins.
- Sync and blanking are pipeline-aligned to the memory read latency; clk is the 25 MHz pixel clock.

Parameters:
- H_TOTAL, 800, pixels per line (counter 0..799)
- V_TOTAL, 525, lines per frame (counter 0..524)
- H_SYNC, 96, hsync low for h 0..95
- V_SYNC, 2, vsync low for v 0..1
- H_VIS_START / H_VIS_END, 144 / 783, visible columns, inclusive
- V_VIS_START / V_VIS_END, 35 / 514, visible lines, inclusive
- RD_LATENCY, 2, clk cycles from rd_addr/rd_en to valid rd_data (range 1..4)

Ports:
- clk  in  1  pixel clock, all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- horizontal_actual_position  out  16  h counter, undelayed
- vertical_actual_position  out  16  v counter, undelayed
- frame_start  out  1  one-cycle pulse when counters enter (0,0)
- rd_addr  out  19  framebuffer read address
- rd_en  out  1  read strobe, high only for visible pixels
- rd_data  in  12  framebuffer word {R[11:8], G[7:4], B[3:0]}
- vga_r, vga_g, vga_b  out  4 each  colour pins
- hsync, vsync  out  1 each  active-low sync

Behaviour:
- Reset (async assert, sync release):
  - h = v = 0; rd_addr = 0; rd_en = 0; RGB = 0.
  - hsync = vsync = 1; frame_start = 0; all pipeline flags cleared to inactive.
- Counters:
  - h increments every clk.
  - h == H_TOTAL-1 -> h = 0 and v increments.
  - v == V_TOTAL-1 at h wrap -> v = 0.
  - Position outputs are the counter registers, zero-extended to 16 bits.
- Address stage (1 cycle):
  - rd_addr <= v*800 + h (19 bits; max 419999, no overflow).
  - Implementation may use an incrementing register that wraps to 0 at frame end, but the value must equal v*800 + h for every (h,v).
  - rd_en <= visible(h,v), where visible = H_VIS_START <= h <= H_VIS_END and V_VIS_START <= v <= V_VIS_END.
  - rd_addr is updated even when rd_en = 0.
- Data stage:
  - rd_data sampled RD_LATENCY cycles after the address stage, registered to the pins one cycle later.
  - Total pipeline depth D = RD_LATENCY + 2 cycles from counter value to pins (D = 4 by default).
- Sync and blanking:
  - hsync_raw = (h >= H_SYNC); vsync_raw = (v >= V_SYNC); visible flag from the counters.
  - All three pass through a D-stage shift register, so pins for counter (h,v) appear exactly D cycles later.
  - Delayed visible = 0 -> RGB forced to 0 regardless of rd_data.
- frame_start:
  - Registered.
  - High for one cycle when counters are (0,0) after a wrap from (799,524).
  - Not asserted for the (0,0) immediately following reset release.
- Reset mid-operation:
  - All outputs go to reset values immediately; in-flight pipeline contents are discarded.
  - After release, counting restarts at (0,0); the pins show inactive sync for the first D cycles.
- rd_data is don't-care when the corresponding rd_en was 0. X on rd_data must not propagate to the pins during blanking.

Test Plan:
- Reset: rst_n = 0 for 10 cycles mid-line -> hsync = vsync = 1, RGB = 0, rd_en = 0, positions = 0 within the same cycle.
- Line timing: after release -> hsync low on pin cycles 4..99 of each line; period exactly 800 cycles; vsync low 1600 cycles per 420000-cycle frame.
- Address: counter (144,35) -> next cycle rd_addr = 28144, rd_en = 1; (783,514) -> 411983, rd_en = 1; (784,35) -> rd_en = 0; (143,35) -> rd_en = 0.
- Data alignment: memory model returns addr[11:0] with 2-cycle latency -> pixel (144,35) appears 4 cycles after counter reaches it as R=0xD, G=0xF, B=0x0; pins one cycle earlier and at the (784,35) position are 0.
- Frame wrap: counters (799,524) -> next (0,0), frame_start = 1 for exactly 1 cycle, rd_addr = 0 next cycle; no frame_start at the first (0,0) after reset.
- Reset mid-frame: rst_n low at counter (400,200) for 3 cycles -> all outputs at reset values immediately; after release counting restarts at (0,0); first hsync low on the pins 4 cycles later; no stale RGB emitted.
